// File: rtl/z16_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle for the Z16 boot loader.
// The master side is the host link plus memory observer; the slave side is the loader.
interface z16_boot_loader_if #(
  parameter int ADDR_W = 16
);
  logic              i_byte_valid;
  logic [7:0]        i_byte;
  logic              o_byte_ready;
  logic              o_imem_wen;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [15:0]       o_imem_wdata;

  modport master (
    output i_byte_valid, i_byte,
    input  o_byte_ready, o_imem_wen, o_imem_addr, o_imem_wdata
  );

  modport slave (
    input  i_byte_valid, i_byte,
    output o_byte_ready, o_imem_wen, o_imem_addr, o_imem_wdata
  );
endinterface

// File: rtl/z16_boot_loader.sv
// Z16 boot loader: packs a little-endian byte stream into 16-bit imem words, then releases the CPU.
// Optional trailing checksum check is enabled by defining Z16_BOOT_CHECKSUM_EN.
module z16_boot_loader #(
  parameter int MAX_WORDS = 256,
  parameter int ADDR_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  z16_boot_loader_if.slave  bus,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

`ifdef Z16_BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM_LO, S_CSUM_HI, S_DONE, S_ERR
  } state_e;
  localparam state_e S_EOD = S_CSUM_LO;
`else
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_DONE, S_ERR
  } state_e;
  localparam state_e S_EOD = S_DONE;
`endif

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       idx_q, idx_d;
  logic [7:0]        lo_q, lo_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
`ifdef Z16_BOOT_CHECKSUM_EN
  logic [15:0]       csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] word;
  logic [15:0] n_full;

  assign accept = bus.i_byte_valid && bus.o_byte_ready;
  assign word   = {bus.i_byte, lo_q};
  assign n_full = {bus.i_byte, len_q[7:0]};

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_LEN_LO;
    else       state_q <= state_d;
  end

  // Next state plus datapath updates; only an accepted byte moves anything
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
`ifdef Z16_BOOT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (accept) begin
      busy_d = 1'b1;
      case (state_q)
        S_LEN_LO: begin
          len_d[7:0] = bus.i_byte;
          state_d    = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d = n_full;
          if ({1'b0, n_full} > MAX_N) state_d = S_ERR;
          else if (n_full == 16'd0)   state_d = S_EOD;
          else                        state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          lo_d    = bus.i_byte;
          state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          wen_d   = 1'b1;
          addr_d  = ADDR_W'({idx_q, 1'b0});
          wdata_d = word;
          idx_d   = idx_q + 16'd1;
`ifdef Z16_BOOT_CHECKSUM_EN
          csum_d  = csum_q + word;
`endif
          state_d = (idx_q + 16'd1 == len_q) ? S_EOD : S_DATA_LO;
        end
`ifdef Z16_BOOT_CHECKSUM_EN
        S_CSUM_LO: begin
          lo_d    = bus.i_byte;
          state_d = S_CSUM_HI;
        end
        S_CSUM_HI: state_d = (word == csum_q) ? S_DONE : S_ERR;
`endif
        default: ;
      endcase
    end
    if (state_d == S_DONE || state_d == S_ERR) busy_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      len_q   <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
`ifdef Z16_BOOT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      len_q   <= len_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
`ifdef Z16_BOOT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Outputs decode from the registered state, so async reset is visible at once
  always_comb begin
    bus.o_byte_ready = !(state_q == S_DONE || state_q == S_ERR);
    o_done           = (state_q == S_DONE);
    o_error          = (state_q == S_ERR);
    o_cpu_rst        = (state_q != S_DONE);
    o_busy           = busy_q;
  end

  assign bus.o_imem_wen   = wen_q;
  assign bus.o_imem_addr  = addr_q;
  assign bus.o_imem_wdata = wdata_q;

endmodule

// File: tb/tb_z16_boot_loader.sv
// Scoreboard bench for z16_boot_loader; follows Z16_BOOT_CHECKSUM_EN to append checksum bytes.
module tb_z16_boot_loader;
  localparam int MAX_WORDS = 256;
  localparam int ADDR_W    = 16;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic o_cpu_rst, o_busy, o_done, o_error;

  z16_boot_loader_if #(.ADDR_W(ADDR_W)) bus();

  z16_boot_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .bus      (bus.slave),
    .o_cpu_rst(o_cpu_rst),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_error  (o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] img[$];
  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strike must match the oldest expected write, in the predicted cycle
  always @(negedge i_clk) begin
    wr_t e;
    if (bus.o_imem_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 bus.o_imem_addr, bus.o_imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr",  32'(bus.o_imem_addr), 32'(e.addr));
        check("wr_data",  32'(bus.o_imem_wdata), 32'(e.data));
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is consumed
  task automatic send_byte(input logic [7:0] b, input int gap, input bit exp_wr,
                           input logic [15:0] a, input logic [15:0] d);
    int t = 0;
    bus.i_byte_valid = 1'b0;
    repeat (gap) @(negedge i_clk);
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    while (bus.o_byte_ready !== 1'b1 && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 20) begin
      check("ready_timeout", 32'(bus.o_byte_ready), 32'd1);
      bus.i_byte_valid = 1'b0;
      return;
    end
    if (exp_wr) exp_q.push_back('{addr: a, data: d, cyc: cyc + 1});
    @(negedge i_clk);
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic load_image(input int max_gap);
    logic [15:0] n, sum, w;
    n   = 16'(img.size());
    sum = 16'h0000;
    send_byte(n[7:0], $urandom_range(max_gap, 0), 1'b0, 16'h0, 16'h0);
    check("busy_after_first", 32'(o_busy), 32'd1);
    send_byte(n[15:8], $urandom_range(max_gap, 0), 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < img.size(); i++) begin
      w = img[i];
      send_byte(w[7:0], $urandom_range(max_gap, 0), 1'b0, 16'h0, 16'h0);
      send_byte(w[15:8], $urandom_range(max_gap, 0), 1'b1, 16'(2 * i), w);
      sum = sum + w;
    end
`ifdef Z16_BOOT_CHECKSUM_EN
    send_byte(sum[7:0], $urandom_range(max_gap, 0), 1'b0, 16'h0, 16'h0);
    send_byte(sum[15:8], $urandom_range(max_gap, 0), 1'b0, 16'h0, 16'h0);
`endif
    repeat (2) @(negedge i_clk);
    check("done",           32'(o_done), 32'd1);
    check("done_cpu_rst",   32'(o_cpu_rst), 32'd0);
    check("done_ready",     32'(bus.o_byte_ready), 32'd0);
    check("done_busy",      32'(o_busy), 32'd0);
    check("done_error",     32'(o_error), 32'd0);
    check("pending_writes", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_state();
    check("rst_ready",   32'(bus.o_byte_ready), 32'd1);
    check("rst_wen",     32'(bus.o_imem_wen), 32'd0);
    check("rst_addr",    32'(bus.o_imem_addr), 32'd0);
    check("rst_wdata",   32'(bus.o_imem_wdata), 32'd0);
    check("rst_cpu_rst", 32'(o_cpu_rst), 32'd1);
    check("rst_busy",    32'(o_busy), 32'd0);
    check("rst_done",    32'(o_done), 32'd0);
    check("rst_error",   32'(o_error), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // Offer bytes while the loader is terminal; none may be consumed or written
  task automatic offer_ignored();
    bus.i_byte       = 8'h55;
    bus.i_byte_valid = 1'b1;
    repeat (4) @(negedge i_clk);
    bus.i_byte_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = 8'h00;
    #3;
    check_reset_state();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;

    // Basic two-word load: 0x1234 @0x0000, 0x5678 @0x0002 (checksum 0x68AC)
    img = '{16'h1234, 16'h5678};
    load_image(0);
    offer_ignored();
    check("done_sticky", 32'(o_done), 32'd1);

    // Zero length
    do_reset();
    img = '{};
    load_image(0);

    // Oversize: N = 0x0101 > 256
    do_reset();
    send_byte(8'h01, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h01, 0, 1'b0, 16'h0, 16'h0);
    @(negedge i_clk);
    check("ovr_error",   32'(o_error), 32'd1);
    check("ovr_cpu_rst", 32'(o_cpu_rst), 32'd1);
    check("ovr_ready",   32'(bus.o_byte_ready), 32'd0);
    check("ovr_done",    32'(o_done), 32'd0);
    check("ovr_busy",    32'(o_busy), 32'd0);
    offer_ignored();
    check("ovr_sticky",  32'(o_error), 32'd1);

    // Four words back-to-back, then the same image with random valid gaps
    do_reset();
    img = '{16'hBEEF, 16'h0001, 16'hFFFF, 16'h8000};
    load_image(0);
    do_reset();
    load_image(3);

    // Capacity boundary: N == MAX_WORDS is accepted, last write at 0x01FE
    do_reset();
    img = '{};
    for (int i = 0; i < MAX_WORDS; i++) img.push_back(16'(i * 16'h0101) ^ 16'hA5C3);
    load_image(0);

`ifdef Z16_BOOT_CHECKSUM_EN
    // Bad checksum: expected 0x0001, sent 0xFFFF
    do_reset();
    send_byte(8'h01, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h00, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h01, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h00, 0, 1'b1, 16'h0000, 16'h0001);
    send_byte(8'hFF, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'hFF, 0, 1'b0, 16'h0, 16'h0);
    @(negedge i_clk);
    check("csum_error",   32'(o_error), 32'd1);
    check("csum_cpu_rst", 32'(o_cpu_rst), 32'd1);
    check("csum_done",    32'(o_done), 32'd0);
    check("csum_pending", exp_q.size(), 32'd0);
`endif

    // Async reset between LO and HI of word 1
    do_reset();
    send_byte(8'h02, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h00, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h34, 0, 1'b0, 16'h0, 16'h0);
    send_byte(8'h12, 0, 1'b1, 16'h0000, 16'h1234);
    send_byte(8'h78, 0, 1'b0, 16'h0, 16'h0);
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_state();
    @(negedge i_clk);
    i_rst = 1'b0;
    img = '{16'h1234, 16'h5678};
    load_image(0);

    repeat (2) @(negedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/z16_boot_loader.md
Name: z16_boot_loader

Overview:
- Upstream neighbour of the Z16 CPU core.
- Receives a program image as a byte stream (valid/ready) from a host link, for example a UART receiver.
- Packs the bytes into 16-bit instruction words and writes them into instruction memory through a dedicated write port.
- Holds the CPU core in reset until the image is fully loaded, then releases it so fetch starts at PC 0x0000.

Parameters:
- MAX_WORDS, 256: capacity of instruction memory in 16-bit words. A declared length above this is an error.
- ADDR_W, 16: width of the instruction-memory byte address.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_byte_valid  input  1  upstream byte available.
- i_byte  input  8  upstream byte data.
- o_byte_ready  output  1  loader can accept a byte this cycle.
- o_imem_wen  output  1  instruction-memory write strike, one-cycle pulse.
- o_imem_addr  output  ADDR_W  instruction-memory byte address (even).
- o_imem_wdata  output  16  instruction word to write.
- o_cpu_rst  output  1  reset to the CPU core; high while loading or on error.
- o_busy  output  1  load in progress.
- o_done  output  1  image loaded and CPU released; sticky.
- o_error  output  1  load failed; sticky.

Behaviour:
- Reset (async assert, sync release) drives all outputs to their reset values:
  - state=S_LEN_LO, o_byte_ready=1, o_imem_wen=0, o_imem_addr=0, o_imem_wdata=0.
  - o_cpu_rst=1, o_busy=0, o_done=0, o_error=0.
  - Word counter=0, length register=0, checksum accumulator=0.
- Byte acceptance: a byte is consumed on a rising edge with i_byte_valid && o_byte_ready. Nothing else advances the FSM.
- o_byte_ready is 1 in S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM_LO and S_CSUM_HI. It is 0 in S_DONE and S_ERR.
- Wire format is little-endian throughout:
  - LEN_LO, LEN_HI: N = number of words.
  - N data words, each as LO then HI.
  - Optional CSUM_LO, CSUM_HI.
- o_busy: 1 from the first accepted byte until entry to S_DONE or S_ERR.
- State transitions, each on an accepted byte unless noted:
  - S_LEN_LO -> S_LEN_HI: latch low byte of N.
  - S_LEN_HI: latch high byte of N.
    - N > MAX_WORDS -> S_ERR.
    - N == 0 -> end-of-data path (see below).
    - Otherwise -> S_DATA_LO.
  - S_DATA_LO -> S_DATA_HI: hold low byte.
  - S_DATA_HI: next cycle, o_imem_wen=1 for exactly one cycle with:
    - o_imem_wdata = {hi, lo}.
    - o_imem_addr = 2 * word_index, matching the CPU PC stride of 2.
    - Word index then increments.
    - If index+1 == N -> end-of-data path. Otherwise -> S_DATA_LO.
  - End-of-data path: S_CSUM_LO when the feature is enabled, S_DONE when it is not.
  - S_DONE: o_cpu_rst=0, o_done=1, from the first cycle in S_DONE.
  - S_ERR: o_cpu_rst=1, o_error=1.
- S_DONE and S_ERR are terminal; only i_rst leaves them.
- Write latency: the write pulse appears 1 cycle after the HI byte is accepted.
  - Back-to-back bytes every cycle are supported.
  - No write is ever pending when a new HI byte is accepted.
- o_imem_addr and o_imem_wdata hold their last values when o_imem_wen=0.
- Address wrap cannot occur, because N ≤ MAX_WORDS is checked first.
- i_rst mid-load aborts immediately. The partially written memory is not cleared. o_cpu_rst stays 1.
- i_byte_valid while o_byte_ready=0 is ignored; the byte is not consumed.

Optional Feature:
- Macro: Z16_BOOT_CHECKSUM_EN.
- Enabled:
  - A 16-bit accumulator adds each data word modulo 2^16.
  - After the last word, states S_CSUM_LO and S_CSUM_HI receive the expected sum.
  - On the HI byte: equal -> S_DONE, mismatch -> S_ERR.
  - For N == 0 the expected sum is 0x0000.
- Disabled:
  - No accumulator and no checksum states.
  - After the last data word, or immediately after LEN_HI when N == 0, go to S_DONE.

Test Plan:
- Basic load: stream 02 00 34 12 78 56 (plus checksum AC 68 if enabled) -> exactly two writes: addr 0x0000 data 0x1234, then addr 0x0002 data 0x5678. Then o_done=1, o_cpu_rst=0, o_byte_ready=0.
- Oversize: N=0x0101 with MAX_WORDS=256 -> S_ERR after LEN_HI. o_error=1, o_cpu_rst=1, zero writes, further bytes not accepted.
- Zero length: 00 00 (plus 00 00 if enabled) -> o_done=1, no write pulses.
- Backpressure and gaps: drop i_byte_valid randomly between bytes of a 4-word image -> writes identical to the gap-free run. Each write is one cycle and follows its HI byte by 1 cycle.
- Bad checksum (macro on): 01 00 01 00 then FF FF -> one write of 0x0001 at 0x0000, then o_error=1 and o_cpu_rst stays 1.
- Async reset mid-load: assert i_rst between the LO and HI bytes of word 1 -> outputs return to reset values without a clock edge. A following full load succeeds from address 0x0000.
